lms_ctr_nios2_dbg_ocimem_monitor: RTL and testbench

//   Sysclk-domain consumer of the debug-slave command pulses (take_action_ocimem_*, jdo).

---
 rtl/lms_ctr_nios2_dbg_ocimem_monitor_if.sv | 20 ++
 rtl/lms_ctr_nios2_dbg_ocimem_monitor.sv | 132 +++++++++++++
 tb/tb_lms_ctr_nios2_dbg_ocimem_monitor.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lms_ctr_nios2_dbg_ocimem_monitor_if.sv
// Avalon-MM debug memory port between the OCI memory monitor (master) and the debug RAM/slave.
interface lms_ctr_nios2_dbg_ocimem_monitor_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/lms_ctr_nios2_dbg_ocimem_monitor.sv
// OCI memory monitor: turns JTAG debug commands into single-word Avalon-MM
// reads/writes with an auto-incrementing address and a stall timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transfer in flight, commands accepted, ready=1
// S_READ  | avm_read held until accepted or the stall timeout expires
// S_WRITE | avm_write held until accepted or the stall timeout expires
module lms_ctr_nios2_dbg_ocimem_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    lms_ctr_nios2_dbg_ocimem_monitor_if.master avm,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mon_q, mon_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    // jdo[37:36] and jdo[33:32] carry nothing this block uses.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

    logic any_take;
    logic stall_expired;
    assign any_take      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // The current stalled cycle is the TIMEOUT_CYCLES-th one.
    assign stall_expired = ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES);

    // Command decode, transfer completion and stall timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = {jdo[31:2], 2'b00};
                    if (jdo[35]) err_d = 1'b0;
                    if (jdo[34]) begin
                        state_d = S_READ;
                        ready_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[31:0];
                    state_d = S_WRITE;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = S_READ;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_READ, S_WRITE: begin
                if (any_take) err_d = 1'b1;
                if (!avm.avm_waitrequest) begin
                    if (state_q == S_READ) mon_d = avm.avm_readdata;
                    addr_d  = addr_q + 32'd4;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (stall_expired) begin
                    if (state_q == S_READ) mon_d = ERR_DATA;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset drops any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = (state_q == S_READ);
    assign avm.avm_write      = (state_q == S_WRITE);
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = 4'hF;
    assign MonDReg            = mon_q;
    assign monitor_ready      = ready_q;
    assign monitor_error      = err_q;

endmodule

// File: tb/tb_lms_ctr_nios2_dbg_ocimem_monitor.sv
// Scoreboard bench for the OCI memory monitor: stimulus pushes expected
// transfers, a monitor process checks the bus and each completion.
module tb_lms_ctr_nios2_dbg_ocimem_monitor;
    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] jdo;
    logic        ta, tn, tb;
    logic [31:0] mon;
    logic        rdy, err;

    always #5 clk = ~clk;

    lms_ctr_nios2_dbg_ocimem_monitor_if bus ();

    lms_ctr_nios2_dbg_ocimem_monitor #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
        .clk                     (clk),
        .reset                   (rst),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta),
        .take_no_action_ocimem_a (tn),
        .take_action_ocimem_b    (tb),
        .avm                     (bus),
        .MonDReg                 (mon),
        .monitor_ready           (rdy),
        .monitor_error           (err)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mon;
        logic [31:0] nxt;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    int          plan = 0;
    logic [31:0] plan_rdata = 32'h0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_mon  = 32'h0;
    bit          m_err  = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    // Slave responder: stalls each strobe for `plan` cycles then accepts.
    initial begin
        int scnt;
        scnt = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.avm_read || bus.avm_write) begin
                bus.avm_waitrequest = (scnt < plan);
                scnt++;
            end else begin
                scnt = 0;
                bus.avm_waitrequest = 1'($urandom_range(0, 1));
            end
            bus.avm_readdata = plan_rdata;
        end
    end

    // Monitor: checks strobes against the head item and each completion.
    initial begin
        int   cyc;
        bit   pr;
        exp_t e;
        cyc = 0;
        pr  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0;
                pr  = 1'b1;
                continue;
            end
            chk("strobe_excl", 32'(bus.avm_read & bus.avm_write), 32'h0);
            chk("byteenable", 32'(bus.avm_byteenable), 32'hF);
            if (bus.avm_read || bus.avm_write) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 32'(bus.avm_read | bus.avm_write), 32'h0);
                end else begin
                    chk("kind", 32'(bus.avm_write), 32'(q[0].is_wr));
                    chk("bus_addr", bus.avm_address, q[0].addr);
                    if (q[0].is_wr) chk("wdata", bus.avm_writedata, q[0].wdata);
                end
                cyc++;
            end
            if (!pr && rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(rdy), 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("mondreg", mon, e.mon);
                    chk("error", 32'(err), 32'(e.err));
                    chk("next_addr", bus.avm_address, e.nxt);
                    chk("strobe_cycles", 32'(cyc), 32'(e.cyc));
                end
                cyc = 0;
            end
            pr = rdy;
        end
    end

    // Drive one command cycle; called at posedge+1, returns at the next posedge+1.
    task automatic pulse(input bit a, input bit b, input bit n, input logic [37:0] d);
        jdo = d;
        ta  = a;
        tb  = b;
        tn  = n;
        @(posedge clk);
        #1;
        ta  = 1'b0;
        tb  = 1'b0;
        tn  = 1'b0;
        jdo = {6'($urandom), 32'($urandom)};
    endtask

    function automatic logic [37:0] mk_jdo(input bit clr, input bit rd, input logic [31:0] v);
        return {2'($urandom), clr, rd, 2'($urandom), v};
    endfunction

    // Model one transfer at the model address and queue its expected outcome.
    task automatic push_xfer(input bit is_wr, input logic [31:0] wd, input int stall,
                             input logic [31:0] rdata, input bit busy);
        exp_t e;
        bit   to;
        plan       = stall;
        plan_rdata = rdata;
        to         = (stall >= T);
        if (busy) m_err = 1'b1;
        e.is_wr = is_wr;
        e.addr  = m_addr;
        e.wdata = wd;
        e.cyc   = to ? T : stall + 1;
        if (to) begin
            m_err = 1'b1;
            if (!is_wr) m_mon = ERR;
        end else begin
            if (!is_wr) m_mon = rdata;
            m_addr = m_addr + 32'd4;
        end
        e.mon = m_mon;
        e.err = m_err;
        e.nxt = m_addr;
        q.push_back(e);
    endtask

    task automatic wait_done(input string n);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rdy) break;
        end
        if (k == 60) chk({n, "_timeout"}, 32'(rdy), 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read_a(input logic [31:0] a, input bit clr, input int stall, input logic [31:0] rd);
        m_addr = {a[31:2], 2'b00};
        if (clr) m_err = 1'b0;
        push_xfer(1'b0, 32'h0, stall, rd, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, mk_jdo(clr, 1'b1, a));
        wait_done("read_a");
    endtask

    task automatic do_read_n(input int stall, input logic [31:0] rd);
        push_xfer(1'b0, 32'h0, stall, rd, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 32'($urandom)));
        wait_done("read_n");
    endtask

    task automatic do_write(input logic [31:0] wd, input int stall);
        push_xfer(1'b1, wd, stall, 32'($urandom), 1'b0);
        pulse(1'b0, 1'b1, 1'b0, mk_jdo(1'($urandom), 1'($urandom), wd));
        wait_done("write");
    endtask

    // Load-only address command, optionally with a colliding ocimem_b pulse.
    task automatic do_load(input logic [31:0] a, input bit clr, input bit also_b);
        m_addr = {a[31:2], 2'b00};
        if (clr) m_err = 1'b0;
        pulse(1'b1, also_b, 1'b0, mk_jdo(clr, 1'b0, a));
        chk("load_addr", bus.avm_address, m_addr);
        chk("load_ready", 32'(rdy), 32'h1);
        chk("load_error", 32'(err), 32'(m_err));
        chk("load_no_write", 32'(bus.avm_write | bus.avm_read), 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        int          kind;
        int          st;
        rst = 1'b1;
        ta  = 1'b0;
        tb  = 1'b0;
        tn  = 1'b0;
        jdo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy), 32'h1);
        chk("rst_error", 32'(err), 32'h0);
        chk("rst_addr", bus.avm_address, 32'h0);
        chk("rst_mondreg", mon, 32'h0);
        chk("rst_strobes", 32'({bus.avm_read, bus.avm_write}), 32'h0);
        chk("rst_wdata", bus.avm_writedata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // read with immediate accept, then a stalled write, then a timed-out read
        do_read_a(32'h0000_0100, 1'b0, 0, 32'h1234_5678);
        do_write(32'hCAFE_F00D, 3);
        do_read_n(20, 32'h5555_AAAA);

        // command pulse while a read is stalled, then clear the error
        push_xfer(1'b0, 32'h0, 4, 32'h0BAD_F00D, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 32'h0));
        pulse(1'b0, 1'b0, 1'b1, mk_jdo(1'b0, 1'b0, 32'h0));
        wait_done("busy_read");
        do_load(32'h0000_0200, 1'b1, 1'b0);

        // address wrap, then colliding ocimem_a + ocimem_b
        do_load(32'hFFFF_FFFC, 1'b0, 1'b0);
        do_read_n(0, 32'h0F0F_0F0F);
        do_load(32'h0000_0240, 1'b0, 1'b1);
        @(negedge clk);
        chk("collide_no_write", 32'(bus.avm_write), 32'h0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            st   = ($urandom_range(0, 3) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 5);
            v    = $urandom;
            @(posedge clk);
            #1;
            case (kind)
                0: do_read_a(v, 1'($urandom), st, 32'($urandom));
                1: do_write(v, st);
                2: do_read_n(st, v);
                default: do_load(v, 1'($urandom), 1'b0);
            endcase
        end

        // reset during a stalled write
        push_xfer(1'b1, 32'h7777_1111, 6, 32'h0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, mk_jdo(1'b0, 1'b0, 32'h7777_1111));
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rstmid_write", 32'(bus.avm_write), 32'h0);
        chk("rstmid_ready", 32'(rdy), 32'h1);
        chk("rstmid_error", 32'(err), 32'h0);
        chk("rstmid_addr", bus.avm_address, 32'h0);
        chk("rstmid_mondreg", mon, 32'h0);
        m_addr = 32'h0;
        m_mon  = 32'h0;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read_n(1, 32'hA5A5_5A5A);
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
